// File: rtl/dpram_fifo_pkg.sv
// Shared constants and head-FSM state encoding for the dual-port-RAM FIFO controller.
package dpram_fifo_pkg;

    localparam int unsigned DATA_W_DEF = 128;
    localparam int unsigned ADDR_W_DEF = 3;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_PEND  = 2'd1,
        ST_HOLD  = 2'd2
    } head_state_e;

endpackage

// File: rtl/dpram_fifo_ctrl_if.sv
// Producer push / consumer pop handshake bundle for dpram_fifo_ctrl.
interface dpram_fifo_ctrl_if
    import dpram_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
);

    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output wr_valid, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data
    );

    modport slave (
        input  wr_valid, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data
    );

endinterface

// File: rtl/dpram_fifo_head.sv
// Head-word tracker: follows the word on the RAM read port (PEND) or parked in out_reg (HOLD).
module dpram_fifo_head
    import dpram_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ram_avail,
    input  logic              rd_ready,
    input  logic [DATA_W-1:0] data_out_b,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              issue
);

    head_state_e       state_q;
    logic [DATA_W-1:0] out_reg_q;
    logic              pop;

    assign rd_valid = (state_q != ST_EMPTY);
    assign pop      = rd_valid & rd_ready;
    assign issue    = ram_avail & ((state_q == ST_EMPTY) | pop);

    always_comb begin
        rd_data = '0;
        case (state_q)
            ST_PEND: rd_data = data_out_b;
            ST_HOLD: rd_data = out_reg_q;
            default: rd_data = '0;
        endcase
    end

    // The RAM output only shows the head for one cycle, so a stalled head is parked in out_reg.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_EMPTY;
            out_reg_q <= '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (issue) state_q <= ST_PEND;
                end
                ST_PEND: begin
                    if (pop) begin
                        state_q <= issue ? ST_PEND : ST_EMPTY;
                    end else begin
                        state_q   <= ST_HOLD;
                        out_reg_q <= data_out_b;
                    end
                end
                ST_HOLD: begin
                    if (pop) state_q <= issue ? ST_PEND : ST_EMPTY;
                end
                default: state_q <= ST_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// Show-ahead FIFO controller driving an external dual-port RAM (A write, B registered read).
// Optional level output enabled by defining DPRAM_FIFO_LEVEL_EN.
module dpram_fifo_ctrl
    import dpram_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    dpram_fifo_ctrl_if.slave  fifo,
    output logic              wr_en_a,
    output logic [ADDR_W-1:0] addr_a,
    output logic [DATA_W-1:0] data_in_a,
    output logic              wr_en_b,
    output logic [ADDR_W-1:0] addr_b,
    output logic [DATA_W-1:0] data_in_b,
    input  logic [DATA_W-1:0] data_out_b
`ifdef DPRAM_FIFO_LEVEL_EN
    ,
    output logic [ADDR_W:0]   level
`endif
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  ram_cnt_q, ram_cnt_d;
    logic              push;
    logic              issue;

    assign fifo.wr_ready = (ram_cnt_q != CNT_W'(DEPTH));
    assign push          = fifo.wr_valid & fifo.wr_ready;

    assign wr_en_a   = push;
    assign addr_a    = wr_ptr_q;
    assign data_in_a = fifo.wr_data;
    assign wr_en_b   = 1'b0;
    assign data_in_b = '0;
    assign addr_b    = rd_ptr_q;

    // ram_cnt counts words in the RAM only; the head word is tracked by the head FSM.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        ram_cnt_d = ram_cnt_q;
        if (push)  wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        if (issue) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        case ({push, issue})
            2'b10:   ram_cnt_d = ram_cnt_q + CNT_W'(1);
            2'b01:   ram_cnt_d = ram_cnt_q - CNT_W'(1);
            default: ram_cnt_d = ram_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ram_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ram_cnt_q <= ram_cnt_d;
        end
    end

    dpram_fifo_head #(
        .DATA_W (DATA_W)
    ) u_head (
        .clk        (clk),
        .rst        (rst),
        .ram_avail  (ram_cnt_q != '0),
        .rd_ready   (fifo.rd_ready),
        .data_out_b (data_out_b),
        .rd_valid   (fifo.rd_valid),
        .rd_data    (fifo.rd_data),
        .issue      (issue)
    );

`ifdef DPRAM_FIFO_LEVEL_EN
    assign level = ram_cnt_q + CNT_W'(fifo.rd_valid);
`endif

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Directed bench for dpram_fifo_ctrl with a behavioural registered-read dual-port RAM.
module tb_dpram_fifo_ctrl;

    localparam int unsigned DATA_W = 128;
    localparam int unsigned ADDR_W = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en_a;
    logic [ADDR_W-1:0] addr_a;
    logic [DATA_W-1:0] data_in_a;
    logic              wr_en_b;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] data_in_b;
    logic [DATA_W-1:0] data_out_b;
`ifdef DPRAM_FIFO_LEVEL_EN
    logic [ADDR_W:0]   level;
`endif

    logic [DATA_W-1:0] mem [2**ADDR_W];

    int n_checks = 0;
    int n_fail   = 0;

    dpram_fifo_ctrl_if #(.DATA_W(DATA_W)) fifo_if ();

    dpram_fifo_ctrl #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo       (fifo_if.slave),
        .wr_en_a    (wr_en_a),
        .addr_a     (addr_a),
        .data_in_a  (data_in_a),
        .wr_en_b    (wr_en_b),
        .addr_b     (addr_b),
        .data_in_b  (data_in_b),
        .data_out_b (data_out_b)
`ifdef DPRAM_FIFO_LEVEL_EN
        ,
        .level      (level)
`endif
    );

    always #5 clk = ~clk;

    // Registered-read RAM: data_out_b shows the word at addr_b from the previous edge.
    always @(posedge clk) begin
        if (wr_en_a) mem[addr_a] <= data_in_a;
        if (wr_en_b) mem[addr_b] <= data_in_b;
        data_out_b <= mem[addr_b];
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, then let combinational outputs settle.
    task automatic cyc(input logic wv, input logic [127:0] wd, input logic rr);
        @(negedge clk);
        fifo_if.wr_valid = wv;
        fifo_if.wr_data  = wd;
        fifo_if.rd_ready = rr;
        #1;
        check_eq("wr_en_b", 128'(wr_en_b), 128'(0));
        check_eq("data_in_b", data_in_b, 128'(0));
    endtask

    task automatic do_reset(input logic wv, input logic rr);
        @(negedge clk);
        rst              = 1'b1;
        fifo_if.wr_valid = wv;
        fifo_if.wr_data  = {DATA_W{1'b1}};
        fifo_if.rd_ready = rr;
        @(negedge clk);
        rst              = 1'b0;
        fifo_if.wr_valid = 1'b0;
        fifo_if.wr_data  = '0;
        fifo_if.rd_ready = 1'b0;
        #1;
        check_eq("rst_wr_ready", 128'(fifo_if.wr_ready), 128'(1));
        check_eq("rst_rd_valid", 128'(fifo_if.rd_valid), 128'(0));
        check_eq("rst_rd_data", fifo_if.rd_data, 128'(0));
        check_eq("rst_wr_en_a", 128'(wr_en_a), 128'(0));
        check_eq("rst_addr_b", 128'(addr_b), 128'(0));
`ifdef DPRAM_FIFO_LEVEL_EN
        check_eq("rst_level", 128'(level), 128'(0));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst              = 1'b1;
        fifo_if.wr_valid = 1'b0;
        fifo_if.wr_data  = '0;
        fifo_if.rd_ready = 1'b0;

        // First word latency: push in cycle 0, read issued cycle 1, presented cycle 2
        do_reset(1'b0, 1'b0);
        cyc(1'b1, 128'hA5, 1'b0);
        check_eq("t1_wr_en_a", 128'(wr_en_a), 128'(1));
        check_eq("t1_addr_a", 128'(addr_a), 128'(0));
        check_eq("t1_data_in_a", data_in_a, 128'hA5);
        check_eq("t1_c0_rd_valid", 128'(fifo_if.rd_valid), 128'(0));
        cyc(1'b0, 128'h0, 1'b0);
        check_eq("t1_c1_addr_b", 128'(addr_b), 128'(0));
        check_eq("t1_c1_rd_valid", 128'(fifo_if.rd_valid), 128'(0));
        cyc(1'b0, 128'h0, 1'b0);
        check_eq("t1_c2_rd_valid", 128'(fifo_if.rd_valid), 128'(1));
        check_eq("t1_c2_rd_data", fifo_if.rd_data, 128'hA5);
        cyc(1'b0, 128'h0, 1'b1);
        check_eq("t1_c3_hold_data", fifo_if.rd_data, 128'hA5);
        cyc(1'b0, 128'h0, 1'b0);
        check_eq("t1_c4_rd_valid", 128'(fifo_if.rd_valid), 128'(0));

        // Fill to DEPTH+1 with no pops, then drain in order
        do_reset(1'b0, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            cyc(1'b1, 128'(k), 1'b0);
            check_eq("fill_wr_en_a", 128'(wr_en_a), 128'(1));
            check_eq("fill_addr_a", 128'(addr_a), 128'((k - 1) % 8));
        end
        cyc(1'b1, 128'd10, 1'b0);
        check_eq("full_wr_ready", 128'(fifo_if.wr_ready), 128'(0));
        check_eq("full_wr_en_a", 128'(wr_en_a), 128'(0));
        check_eq("full_rd_data", fifo_if.rd_data, 128'd1);
`ifdef DPRAM_FIFO_LEVEL_EN
        check_eq("full_level", 128'(level), 128'd9);
`endif
        for (int k = 1; k <= 9; k++) begin
            cyc(1'b0, 128'h0, 1'b1);
            check_eq("drain_rd_valid", 128'(fifo_if.rd_valid), 128'(1));
            check_eq("drain_rd_data", fifo_if.rd_data, 128'(k));
        end
        cyc(1'b0, 128'h0, 1'b0);
        check_eq("drained_rd_valid", 128'(fifo_if.rd_valid), 128'(0));
        check_eq("drained_wr_ready", 128'(fifo_if.wr_ready), 128'(1));

        // Streaming push+pop every cycle across pointer wrap
        do_reset(1'b0, 1'b0);
        cyc(1'b1, 128'd100, 1'b0);
        cyc(1'b1, 128'd101, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 128'(102 + i), 1'b1);
            check_eq("stream_rd_valid", 128'(fifo_if.rd_valid), 128'(1));
            check_eq("stream_rd_data", fifo_if.rd_data, 128'(100 + i));
            check_eq("stream_wr_en_a", 128'(wr_en_a), 128'(1));
            check_eq("stream_addr_a", 128'(addr_a), 128'((2 + i) % 8));
        end
        cyc(1'b0, 128'h0, 1'b1);
        check_eq("stream_tail0", fifo_if.rd_data, 128'd120);
        cyc(1'b0, 128'h0, 1'b1);
        check_eq("stream_tail1", fifo_if.rd_data, 128'd121);
        cyc(1'b0, 128'h0, 1'b0);
        check_eq("stream_empty", 128'(fifo_if.rd_valid), 128'(0));

        // Consumer stall moves head from PEND into HOLD
        do_reset(1'b0, 1'b0);
        cyc(1'b1, 128'd50, 1'b0);
        cyc(1'b1, 128'd51, 1'b0);
        cyc(1'b1, 128'd52, 1'b0);
        check_eq("stall_c2_data", fifo_if.rd_data, 128'd50);
        cyc(1'b0, 128'h0, 1'b0);
        check_eq("stall_c3_data", fifo_if.rd_data, 128'd50);
`ifdef DPRAM_FIFO_LEVEL_EN
        check_eq("stall_level", 128'(level), 128'd3);
`endif
        cyc(1'b0, 128'h0, 1'b0);
        check_eq("stall_c4_data", fifo_if.rd_data, 128'd50);
        cyc(1'b0, 128'h0, 1'b1);
        check_eq("stall_pop_data", fifo_if.rd_data, 128'd50);
        cyc(1'b0, 128'h0, 1'b0);
        check_eq("stall_next_valid", 128'(fifo_if.rd_valid), 128'(1));
        check_eq("stall_next_data", fifo_if.rd_data, 128'd51);
        cyc(1'b0, 128'h0, 1'b0);
        check_eq("stall_next_hold", fifo_if.rd_data, 128'd51);

        // Reset with words queued and concurrent push/pop requests
        do_reset(1'b0, 1'b0);
        for (int k = 0; k < 5; k++) cyc(1'b1, 128'(60 + k), 1'b0);
        do_reset(1'b1, 1'b1);
        cyc(1'b1, 128'd70, 1'b0);
        check_eq("mrst_wr_en_a", 128'(wr_en_a), 128'(1));
        check_eq("mrst_addr_a", 128'(addr_a), 128'(0));
        cyc(1'b0, 128'h0, 1'b0);
        check_eq("mrst_c1_valid", 128'(fifo_if.rd_valid), 128'(0));
        cyc(1'b0, 128'h0, 1'b0);
        check_eq("mrst_c2_valid", 128'(fifo_if.rd_valid), 128'(1));
        check_eq("mrst_c2_data", fifo_if.rd_data, 128'd70);

        // Pop requests against an empty FIFO are ignored
        do_reset(1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 128'h0, 1'b1);
            check_eq("epop_rd_valid", 128'(fifo_if.rd_valid), 128'(0));
            check_eq("epop_addr_b", 128'(addr_b), 128'(0));
            check_eq("epop_wr_ready", 128'(fifo_if.wr_ready), 128'(1));
        end
        cyc(1'b1, 128'd80, 1'b1);
        check_eq("epop_push_addr_a", 128'(addr_a), 128'(0));
        cyc(1'b0, 128'h0, 1'b1);
        check_eq("epop_c1_addr_b", 128'(addr_b), 128'(0));
        check_eq("epop_c1_valid", 128'(fifo_if.rd_valid), 128'(0));
        cyc(1'b0, 128'h0, 1'b1);
        check_eq("epop_c2_valid", 128'(fifo_if.rd_valid), 128'(1));
        check_eq("epop_c2_data", fifo_if.rd_data, 128'd80);
        check_eq("epop_c2_addr_b", 128'(addr_b), 128'(1));
        cyc(1'b0, 128'h0, 1'b1);
        check_eq("epop_c3_valid", 128'(fifo_if.rd_valid), 128'(0));
        check_eq("epop_c3_addr_b", 128'(addr_b), 128'(1));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
